// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake and divide-by-zero detection.
module restoring_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH+1:0] aShift;
  logic [WIDTH+1:0] trial;
  logic             trialNeg;
  logic [WIDTH:0]   aNext;
  logic [WIDTH-1:0] qNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // The trial subtraction is one bit wider than A so its MSB is a clean borrow flag.
  always_comb begin
    aShift   = {a_q, q_q[WIDTH-1]};
    trial    = aShift - {2'b00, m_q};
    trialNeg = trial[WIDTH+1];
    aNext    = trialNeg ? aShift[WIDTH:0] : trial[WIDTH:0];
    qNext    = {q_q[WIDTH-2:0], ~trialNeg};

    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = dividend;
          m_d     = divisor;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = (divisor == '0) ? ZERO : RUN;
        end
      end
      RUN: begin
        a_d   = aNext;
        q_d   = qNext;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = qNext;
          rem_d   = aNext[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ZERO: begin
        // Q still holds the captured dividend, reported back as the remainder.
        quot_d  = '1;
        rem_d   = q_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
